// File: rtl/shift_word_rx_pkg.sv
// shift_word_rx_pkg: shared serial-link direction constants and counter sizing
package shift_word_rx_pkg;
  localparam logic DIR_MSB_FIRST = 1'b0;
  localparam logic DIR_LSB_FIRST = 1'b1;
  function automatic int cnt_w(input int size);
    return $clog2(size);
  endfunction
endpackage

// File: rtl/shift_word_rx_word_hold_buf.sv
// word_hold_buf: one-entry valid/ready hold register that drops words arriving while full
module word_hold_buf #(
  parameter int w = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [w-1:0] din,
  input  logic         rdy,
  output logic [w-1:0] dout,
  output logic         vld,
  output logic         drop
);
  logic xfer;
  always_comb begin
    xfer = vld & rdy;
    drop = load & vld & ~xfer;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      dout <= '0;
      vld  <= 1'b0;
    end else if (load & (~vld | xfer)) begin
      dout <= din;
      vld  <= 1'b1;
    end else if (xfer) begin
      vld <= 1'b0;
    end
  end
endmodule

// File: rtl/shift_word_rx.sv
// shift_word_rx: serial-to-parallel receiver with sof resync and a one-entry output buffer
module shift_word_rx
  import shift_word_rx_pkg::*;
#(
  parameter int size = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            srl_in,
  input  logic            srl_vld,
  input  logic            sof,
  input  logic            dir,
  input  logic            word_rdy,
  input  logic            err_clr,
  output logic [size-1:0] word_out,
  output logic            word_vld,
  output logic            busy,
  output logic            ovf,
  output logic            sync_err
);
  localparam int CW = cnt_w(size);
  logic [size-1:0] sh, base, sh_nx;
  logic [CW-1:0] cnt, cnt_b, cnt_nx;
  logic dir_q, dir_eff, done, drop, sync_set;
  always_comb begin
    dir_eff  = (cnt == '0 || sof) ? dir : dir_q;
    base     = sof ? '0 : sh;
    cnt_b    = sof ? '0 : cnt;
    sh_nx    = (dir_eff == DIR_LSB_FIRST) ? {srl_in, base[size-1:1]} : {base[size-2:0], srl_in};
    done     = srl_vld & (cnt_b == CW'(size - 1));
    cnt_nx   = done ? '0 : cnt_b + CW'(1);
    sync_set = srl_vld & sof & (cnt != '0);
    busy     = cnt != '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sh       <= '0;
      cnt      <= '0;
      dir_q    <= DIR_MSB_FIRST;
      ovf      <= 1'b0;
      sync_err <= 1'b0;
    end else begin
      if (srl_vld) begin
        sh    <= sh_nx;
        cnt   <= cnt_nx;
        dir_q <= dir_eff;
      end
      ovf      <= drop | (ovf & ~err_clr);
      sync_err <= sync_set | (sync_err & ~err_clr);
    end
  end
  word_hold_buf #(.w(size)) u_hold (
    .clk (clk),
    .rst (rst),
    .load(done),
    .din (sh_nx),
    .rdy (word_rdy),
    .dout(word_out),
    .vld (word_vld),
    .drop(drop)
  );
endmodule

// File: tb/tb_shift_word_rx.sv
// tb_shift_word_rx: directed-vector bench for shift_word_rx
module tb_shift_word_rx;
  logic clk = 1'b0;
  logic rst, srl_in, srl_vld, sof, dir, word_rdy, err_clr;
  logic [7:0] word_out;
  logic word_vld, busy, ovf, sync_err;
  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  shift_word_rx #(.size(8)) dut (
    .clk(clk), .rst(rst), .srl_in(srl_in), .srl_vld(srl_vld), .sof(sof),
    .dir(dir), .word_rdy(word_rdy), .err_clr(err_clr), .word_out(word_out),
    .word_vld(word_vld), .busy(busy), .ovf(ovf), .sync_err(sync_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bit_in(input logic b, input logic s);
    srl_vld = 1'b1;
    srl_in  = b;
    sof     = s;
    @(posedge clk);
    #1;
    srl_vld = 1'b0;
    sof     = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // bits go out in wire order matching d: MSB-first for d=0, LSB-first for d=1
  task automatic send_word(input logic [7:0] w, input logic d, input logic s, input logic gap, input logic chk_busy);
    dir = d;
    for (int i = 0; i < 8; i++) begin
      bit_in(d ? w[i] : w[7-i], s && i == 0);
      if (chk_busy) chk($sformatf("busy_b%0d", i + 1), busy, i < 7);
      if (gap && i < 7) idle(1);
    end
  endtask

  initial begin
    logic [7:0] seq;
    rst = 1'b1; srl_in = 1'b0; srl_vld = 1'b0; sof = 1'b0; dir = 1'b0;
    word_rdy = 1'b1; err_clr = 1'b0;
    idle(2);
    chk("rst_out", word_out, 0);
    chk("rst_vld", word_vld, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_sync", sync_err, 0);
    rst = 1'b0;
    idle(1);

    send_word(8'hC0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("msb_out", word_out, 8'hC0);
    chk("msb_vld", word_vld, 1);
    idle(1);
    chk("msb_vld_drop", word_vld, 0);

    seq = 8'hC0;
    dir = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i == 4) dir = 1'b0;
      bit_in(seq[7-i], i == 0);
    end
    chk("lsb_out", word_out, 8'h03);
    chk("lsb_vld", word_vld, 1);
    idle(1);

    send_word(8'hA5, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("gap_out", word_out, 8'hA5);
    chk("gap_vld", word_vld, 1);
    idle(1);

    word_rdy = 1'b0;
    send_word(8'h11, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ovf_w1_out", word_out, 8'h11);
    chk("ovf_w1_flag", ovf, 0);
    send_word(8'h22, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ovf_w2_out", word_out, 8'h11);
    chk("ovf_w2_vld", word_vld, 1);
    chk("ovf_set", ovf, 1);
    word_rdy = 1'b1;
    idle(1);
    chk("ovf_xfer_vld", word_vld, 0);
    chk("ovf_xfer_out", word_out, 8'h11);
    chk("ovf_sticky", ovf, 1);
    err_clr = 1'b1;
    idle(1);
    err_clr = 1'b0;
    chk("ovf_clr", ovf, 0);

    dir = 1'b0;
    bit_in(1'b1, 1'b0);
    bit_in(1'b0, 1'b0);
    bit_in(1'b1, 1'b0);
    chk("resync_busy", busy, 1);
    chk("resync_pre", sync_err, 0);
    send_word(8'h5A, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("resync_err", sync_err, 1);
    chk("resync_out", word_out, 8'h5A);
    chk("resync_vld", word_vld, 1);
    word_rdy = 1'b0;
    seq = 8'h3C;
    for (int i = 0; i < 8; i++) begin
      if (i == 7) word_rdy = 1'b1;
      bit_in(seq[7-i], 1'b0);
      chk($sformatf("b2b_vld_%0d", i), word_vld, 1);
    end
    chk("b2b_out", word_out, 8'h3C);
    chk("b2b_ovf", ovf, 0);
    idle(1);
    chk("b2b_drain", word_vld, 0);
    err_clr = 1'b1;
    idle(1);
    err_clr = 1'b0;
    chk("sync_clr", sync_err, 0);

    word_rdy = 1'b0;
    send_word(8'h77, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("pend_vld", word_vld, 1);
    for (int i = 0; i < 4; i++) bit_in(1'b1, 1'b0);
    rst = 1'b1;
    bit_in(1'b1, 1'b0);
    rst = 1'b0;
    chk("mrst_out", word_out, 0);
    chk("mrst_vld", word_vld, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_ovf", ovf, 0);
    chk("mrst_sync", sync_err, 0);
    word_rdy = 1'b1;
    send_word(8'h96, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("clean_out", word_out, 8'h96);
    chk("clean_vld", word_vld, 1);
    chk("clean_sync", sync_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/shift_word_rx.md
# shift_word_rx

Serial-to-parallel receiver for the serial stream our universal shift register emits on its serial output. It collects `size` bits qualified by a valid strobe, either MSB-first (left-shift mode) or LSB-first (right-shift mode), and resynchronises on a start-of-frame marker. Each completed word is presented on a one-entry valid/ready output buffer, with sticky overflow and sync-error flags. It sits at the receiving end of a serial link between two datapath blocks.

## Interface
- `size`, 8: word width in bits; must be ≥ 2.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `srl_in` in 1: serial data bit, sampled only when `srl_vld`=1.
- `srl_vld` in 1: bit-valid strobe; gaps of any length are allowed.
- `sof` in 1: start of frame, qualified by `srl_vld`; marks the current bit as bit 0 of a new word.
- `dir` in 1: 0 = MSB-first, 1 = LSB-first; latched at the first bit of each word.
- `word_rdy` in 1: downstream accept.
- `err_clr` in 1: clears `ovf` and `sync_err`.
- `word_out` out size: assembled word.
- `word_vld` out 1: `word_out` holds an unconsumed word.
- `busy` out 1: a partial word is in progress (bit count ≠ 0).
- `ovf` out 1: sticky; a completed word was dropped.
- `sync_err` out 1: sticky; `sof` arrived with a partial word in progress.

## Operation
- State: shift register `sh[size-1:0]`, bit counter `cnt` (0..size-1), latched direction `dir_q`, hold register `word_out`/`word_vld`.
- A bit is accepted when `srl_vld`=1. Cycles with `srl_vld`=0 change nothing in the assembly path.
- Accepting a bit with `cnt`=0, or with `sof`=1, latches `dir_q`←`dir`. Changes to `dir` mid-word are ignored.
- MSB-first: `sh`←{`sh[size-2:0]`, `srl_in`}. The first bit received ends up in bit `size-1`.
- LSB-first: `sh`←{`srl_in`, `sh[size-1:1]`}. The first bit received ends up in bit 0.
- `cnt` increments on each accepted bit. When the accepted bit has `cnt`=size-1, the word is complete:
  - the completed value (including this bit) is the load candidate;
  - `cnt` wraps to 0.
- `sof`=1 with `srl_vld`=1:
  - the partial word is discarded and the bit is taken as bit 0 (`cnt`←1);
  - if `cnt`≠0 beforehand, `sync_err` is set;
  - for `size`≥2, `sof` never completes a word on its own.
- `sof` with `srl_vld`=0 is ignored.
- Hold buffer, evaluated each cycle:
  - transfer = `word_vld`∧`word_rdy`;
  - on completion, if `word_vld`=0 or transfer: load `word_out`, keep `word_vld`=1;
  - on completion while `word_vld`=1 and no transfer: drop the new word, keep the old `word_out`, set `ovf`;
  - transfer with no completion: `word_vld`←0, and `word_out` keeps its last value.
- `word_out` is stable while `word_vld`=1 and not transferred.
- `err_clr` clears both sticky flags. If a flag's set condition occurs in the same cycle, set wins.
- `busy` = (`cnt`≠0), combinational from the register.

## Timing
- Reset values: `word_out`=0, `word_vld`=0, `busy`=0, `ovf`=0, `sync_err`=0, `sh`=0, `cnt`=0, `dir_q`=0.
- A reset mid-word or with a pending word discards both. Reset overrides all other inputs.
- Latency: last bit accepted at edge N → `word_vld`=1 and `word_out` valid after edge N.
- Throughput: one bit per cycle sustained. Downstream must accept within `size` cycles of `word_vld` rising to avoid overflow.
- Completion and transfer in the same cycle give back-to-back words with `word_vld` held at 1.
- `word_vld`, `word_out`, `ovf` and `sync_err` are registered. `busy` is decoded from registered `cnt`.

## Structure
- Shared package holds:
  - constants `DIR_MSB_FIRST`=1'b0 and `DIR_LSB_FIRST`=1'b1;
  - a counter-width function, clog2 of `size`, used here and in any matching transmitter.
- Natural sub-module: `word_hold_buf`, the one-entry valid/ready holding register with drop/overflow detection. The assembly shift, counter and sof logic stay in the top level.

## Test plan
- MSB-first: `dir`=0, `sof` on the first bit, bits 1,1,0,0,0,0,0,0 with `word_rdy`=1 → `word_out`=8'hC0 and `word_vld`=1 for one cycle after the 8th bit.
- LSB-first: the same bit sequence with `dir`=1 → `word_out`=8'h03. Toggling `dir` at bit 4 has no effect.
- Gapped input: 8 bits of 0xA5 MSB-first with `srl_vld` low on alternate cycles → 0xA5, and `busy` high from bit 1 through bit 7.
- Overflow: `word_rdy`=0 across two full words, 0x11 then 0x22 → `word_out` stays 0x11 and `ovf`=1. Then `word_rdy`=1 transfers 0x11, and `err_clr` clears `ovf`.
- Resync: 3 bits, then `sof` with bits of 0x5A → `sync_err`=1 and `word_out`=0x5A. Back-to-back 0x5A, 0x3C with `word_rdy`=1 → `word_vld` stays high and no `ovf`.
- Reset: `rst` pulsed at bit 5 of a word with a pending word → all outputs 0 next cycle, and the following 8 bits form a clean word.
